// File: rtl/mcsr_unit_pkg.sv
// Shared CSR addresses, write-type encoding, status/interrupt bit positions and cause codes.
// Counter CSR addresses are only decoded by mcsr_unit when CSR_COUNTERS_EN is defined.
package csr_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned CAUSE_W = 5;

  localparam logic [ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [ADDR_W-1:0] CSR_MISA      = 12'h301;
  localparam logic [ADDR_W-1:0] CSR_MIE       = 12'h304;
  localparam logic [ADDR_W-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [ADDR_W-1:0] CSR_MEPC      = 12'h341;
  localparam logic [ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [ADDR_W-1:0] CSR_MTVAL     = 12'h343;
  localparam logic [ADDR_W-1:0] CSR_MIP       = 12'h344;
  localparam logic [ADDR_W-1:0] CSR_MVENDORID = 12'hF11;
  localparam logic [ADDR_W-1:0] CSR_MARCHID   = 12'hF12;
  localparam logic [ADDR_W-1:0] CSR_MIMPID    = 12'hF13;
  localparam logic [ADDR_W-1:0] CSR_MHARTID   = 12'hF14;
  localparam logic [ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100;

  typedef enum logic [1:0] {
    WT_NONE  = 2'b00,
    WT_WRITE = 2'b01,
    WT_SET   = 2'b10,
    WT_CLEAR = 2'b11
  } write_type_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MSI_BIT      = 3;
  localparam int unsigned MIE_MTI_BIT      = 7;
  localparam int unsigned MIE_MEI_BIT      = 11;

  localparam logic [CAUSE_W-1:0] IRQ_CODE_SW    = 5'd3;
  localparam logic [CAUSE_W-1:0] IRQ_CODE_TIMER = 5'd7;
  localparam logic [CAUSE_W-1:0] IRQ_CODE_EXT   = 5'd11;

  // Place {ext, timer, sw} flags at their mie/mip bit positions.
  function automatic logic [XLEN-1:0] irq_word(input logic [2:0] flags);
    logic [XLEN-1:0] w;
    w              = '0;
    w[MIE_MEI_BIT] = flags[2];
    w[MIE_MTI_BIT] = flags[1];
    w[MIE_MSI_BIT] = flags[0];
    return w;
  endfunction

endpackage

// File: rtl/mcsr_unit_if.sv
// CSR access, trap/return and interrupt signal bundle between the core and mcsr_unit.
interface mcsr_unit_if;
  import csr_pkg::*;

  logic [ADDR_W-1:0]  addr;
  logic [XLEN-1:0]    bus;
  logic               read;
  logic               write;
  write_type_e        write_type;
  logic               trap;
  logic               trap_irq;
  logic [CAUSE_W-1:0] trap_cause;
  logic [XLEN-1:0]    trap_val;
  logic               ret;
  logic               retire;
  logic               irq_ext;
  logic               irq_timer;
  logic               irq_sw;
  logic [XLEN-1:0]    csr_out;
  logic               invalid;
  logic               irq_pending;
  logic [CAUSE_W-1:0] irq_cause;
  logic [XLEN-1:0]    trap_vector;

  modport master (
    output addr, bus, read, write, write_type, trap, trap_irq, trap_cause, trap_val,
           ret, retire, irq_ext, irq_timer, irq_sw,
    input  csr_out, invalid, irq_pending, irq_cause, trap_vector
  );

  modport slave (
    input  addr, bus, read, write, write_type, trap, trap_irq, trap_cause, trap_val,
           ret, retire, irq_ext, irq_timer, irq_sw,
    output csr_out, invalid, irq_pending, irq_cause, trap_vector
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half overwrite; a half write suppresses that cycle's increment.
// Only built when CSR_COUNTERS_EN is defined.
`ifdef CSR_COUNTERS_EN
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);
  logic [63:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)          r_count        <= '0;
    else if (i_wr_lo) r_count[31:0]  <= i_wdata;
    else if (i_wr_hi) r_count[63:32] <= i_wdata;
    else if (i_inc)   r_count        <= r_count + 64'd1;
  end

  assign o_count = r_count;
endmodule
`endif

// File: rtl/mcsr_unit.sv
// Machine-mode CSR file: trap entry/return, interrupt pending/cause and trap vector generation.
// Define CSR_COUNTERS_EN to add mcycle/minstret (and their user aliases).
module mcsr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MHARTID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h4
) (
  input logic        clk,
  input logic        rst,
  mcsr_unit_if.slave csr
);
  logic [XLEN-1:0]    w_rdata;
  logic [XLEN-1:0]    w_wdata;
  logic               w_impl;
  logic               w_wr_en;
  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [2:0]         r_mie;
  logic [2:0]         r_mip;
  logic [29:0]        r_mtvec_base;
  logic               r_mtvec_mode;
  logic [XLEN-1:0]    r_mscratch;
  logic [29:0]        r_mepc;
  logic               r_mcause_irq;
  logic [CAUSE_W-1:0] r_mcause_code;
  logic [XLEN-1:0]    r_mtval;
  logic [2:0]         w_pend;

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (1'b1),
    .i_wr_lo (w_wr_en && csr.addr == CSR_MCYCLE),
    .i_wr_hi (w_wr_en && csr.addr == CSR_MCYCLEH),
    .i_wdata (w_wdata),
    .o_count (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (csr.retire),
    .i_wr_lo (w_wr_en && csr.addr == CSR_MINSTRET),
    .i_wr_hi (w_wr_en && csr.addr == CSR_MINSTRETH),
    .i_wdata (w_wdata),
    .o_count (w_minstret)
  );
`else
  logic w_unused;
  assign w_unused = csr.retire;
`endif

  // Read mux; anything not listed is unimplemented.
  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    case (csr.addr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: w_rdata = '0;
      CSR_MHARTID:  w_rdata = MHARTID;
      CSR_MISA:     w_rdata = MISA_VALUE;
      CSR_MSTATUS: begin
        w_rdata[12:11]            = 2'b11;
        w_rdata[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
        w_rdata[MSTATUS_MIE_BIT]  = r_mstatus_mie;
      end
      CSR_MIE:      w_rdata = irq_word(r_mie);
      CSR_MIP:      w_rdata = irq_word(r_mip);
      CSR_MTVEC:    w_rdata = {r_mtvec_base, 1'b0, r_mtvec_mode};
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = {r_mepc, 2'b00};
      CSR_MCAUSE:   w_rdata = {r_mcause_irq, 26'd0, r_mcause_code};
      CSR_MTVAL:    w_rdata = r_mtval;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_minstret[63:32];
`endif
      default:      w_impl = 1'b0;
    endcase
  end

  always_comb begin
    w_wdata = w_rdata;
    case (csr.write_type)
      WT_WRITE: w_wdata = csr.bus;
      WT_SET:   w_wdata = w_rdata | csr.bus;
      WT_CLEAR: w_wdata = w_rdata & ~csr.bus;
      default:  w_wdata = w_rdata;
    endcase
  end

  assign csr.csr_out = w_rdata;
  assign csr.invalid = (csr.read | csr.write) &
                       (~w_impl | (csr.write & (csr.write_type != WT_NONE) & (csr.addr[11:10] == 2'b11)));
  assign w_wr_en     = csr.write & (csr.write_type != WT_NONE) & ~csr.invalid & ~csr.trap & ~csr.ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mip          <= '0;
      r_mtvec_base   <= MTVEC_RESET[31:2];
      r_mtvec_mode   <= MTVEC_RESET[0];
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause_irq   <= 1'b0;
      r_mcause_code  <= '0;
      r_mtval        <= '0;
    end else begin
      r_mip <= {csr.irq_ext, csr.irq_timer, csr.irq_sw};
      if (csr.trap) begin
        r_mepc         <= csr.bus[31:2];
        r_mcause_irq   <= csr.trap_irq;
        r_mcause_code  <= csr.trap_cause;
        r_mtval        <= csr.trap_irq ? '0 : csr.trap_val;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (csr.ret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr_en) begin
        case (csr.addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_wdata[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= w_wdata[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:      r_mie <= {w_wdata[MIE_MEI_BIT], w_wdata[MIE_MTI_BIT], w_wdata[MIE_MSI_BIT]};
          CSR_MTVEC: begin
            r_mtvec_base <= w_wdata[31:2];
            // Reserved modes 2/3 leave the current mode untouched.
            if (!w_wdata[1]) r_mtvec_mode <= w_wdata[0];
          end
          CSR_MSCRATCH: r_mscratch <= w_wdata;
          CSR_MEPC:     r_mepc     <= w_wdata[31:2];
          CSR_MCAUSE: begin
            r_mcause_irq  <= w_wdata[31];
            r_mcause_code <= w_wdata[CAUSE_W-1:0];
          end
          CSR_MTVAL:    r_mtval    <= w_wdata;
          default: ;
        endcase
      end
    end
  end

  // Interrupt arbitration: external > software > timer.
  assign w_pend          = r_mip & r_mie;
  assign csr.irq_pending = r_mstatus_mie & (|w_pend);
  always_comb begin
    csr.irq_cause = '0;
    if (csr.irq_pending) begin
      if (w_pend[2])      csr.irq_cause = IRQ_CODE_EXT;
      else if (w_pend[0]) csr.irq_cause = IRQ_CODE_SW;
      else                csr.irq_cause = IRQ_CODE_TIMER;
    end
  end

  assign csr.trap_vector = {r_mtvec_base, 2'b00} +
                           ((r_mtvec_mode & csr.trap_irq) ? {25'd0, csr.trap_cause, 2'b00} : 32'd0);
endmodule
